shared_unit_arb: RTL
====================

# shared_unit_arb

Round-robin arbiter and completion tracker for a fixed-latency functional unit shared by N pipeline requesters (e.g. multiplier/divider shared between issue slots). Grants at most one requester per cycle, enforces the unit's initiation interval, and routes a one-hot completion pulse back to the granted requester exactly LATENCY cycles after its grant. It sits between the requesting stages and the unit's operand-select mux; the unit itself is a plain fixed-latency delay pipeline.

## Interface
- N, 2: number of requesters (≥1).
- LATENCY, 3: cycles from grant to completion pulse (≥0).
- II, 1: initiation interval; minimum cycles between successive grants (≥1).

- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low (0 = reset); sampled on rising edge of clock.
- req  input  N  per-requester request level; held high until granted.
- hold  input  1  pipeline stall; when 1 no new grant is issued.
- gnt  output  N  one-hot grant, combinational from req, hold and state; at most one bit set.
- sel  output  clog2(N) (min 1)  index of granted requester; 0 when gnt == 0.
- done  output  N  one-hot completion pulse for the requester granted LATENCY cycles earlier.
- busy  output  1  1 while any grant is in flight or the II cooldown is nonzero.

## Operation
- State: round-robin pointer ptr (0..N-1), cooldown counter cd (0..II-1), tag pipeline of LATENCY stages, each {valid, index}.
- Grant eligibility: reset == 1, hold == 0, cd == 0, req != 0.
- Arbitration: scan indices ptr, ptr+1, …, wrapping mod N; first index with req set is granted. gnt = one-hot of that index, sel = index.
- On a grant to i: ptr ← (i+1) mod N; cd ← II-1; tag stage 0 ← {1, i}.
- No grant: ptr unchanged; stage 0 ← {0, 0}; cd ← cd-1 if cd > 0.
- Tag pipeline shifts one stage every cycle regardless of hold; the unit never stalls, so hold does not delay completions.
- done = one-hot(index) of last stage when its valid is 1, else 0.
- LATENCY == 0: no pipeline; done = gnt (same cycle, combinational).
- II == 1: cd permanently 0; a grant is possible every cycle.
- N == 1: ptr permanently 0; sel permanently 0.
- busy = (any tag stage valid) | (cd != 0).
- Requester dropping req before grant is legal; it is simply not granted. req bits of a requester with a grant in flight may be reasserted immediately; multiple in-flight grants to one requester are legal and complete in order.

## Timing
- Reset (reset == 0 at rising edge): ptr ← 0, cd ← 0, all tag valids ← 0. While reset is low, gnt = 0, sel = 0, done = 0; after the first edge busy = 0.
- Reset mid-operation: all in-flight grants discarded; no done pulse is ever produced for them.
- Grant at cycle t ⇒ done bit asserted during cycle t+LATENCY for exactly one cycle.
- With II > 1, next grant earliest at cycle t+II.
- hold == 1 in the eligible cycle suppresses the grant; ptr and cd do not advance from that grant, but cd still counts down.
- Simultaneous grant and done in one cycle is normal (back-to-back traffic); both outputs valid independently.
- All state updates on rising edge of clock only; gnt/sel/done/busy have no dependence on clock edges other than through state.

## Test plan
- Reset: hold reset low 2 cycles with req = 3'b111 (N=3) -> gnt = 0, done = 0; after release with req = 3'b111 steady, gnts cycle 001, 010, 100, 001 on consecutive cycles.
- Latency: N=3, LATENCY=3, II=1; single req[1] pulse granted at cycle 5 -> done = 3'b010 only in cycle 8; busy high cycles 6–8, low in 9.
- Initiation interval: II=2, req = 2'b11 steady (N=2) -> grants 01 at t, none at t+1, 10 at t+2, 01 at t+4; done pulses follow each by LATENCY.
- Hold: req = 3'b101, ptr = 0, hold = 1 for 3 cycles -> gnt = 0, ptr stays 0; hold drops -> gnt = 3'b001 that cycle, then 3'b100.
- Reset mid-flight: grants at cycles 10, 11 with LATENCY=3; reset low at cycle 12 -> no done in cycles 13–14, busy = 0 from cycle 13, next grant after release goes to index 0.
- LATENCY=0, II=1: req = 2'b10 -> done = 2'b10 in the same cycle as gnt = 2'b10; busy stays 0.

Source files
------------

// File: rtl/shared_unit_arb_if.sv
// Request/grant/completion bundle between the requesting stages and
// the shared-unit arbiter.
interface shared_unit_arb_if #(
   parameter int N = 2
);
   localparam int SW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]  req;
   logic          hold;
   logic [N-1:0]  gnt;
   logic [SW-1:0] sel;
   logic [N-1:0]  done;
   logic          busy;

   modport master (
      output req, hold,
      input  gnt, sel, done, busy
   );

   modport slave (
      input  req, hold,
      output gnt, sel, done, busy
   );
endinterface

// File: rtl/shared_unit_arb.sv
// Round-robin arbiter for a shared fixed-latency unit, with II cooldown
// and a tag pipeline that returns a one-hot done to the granted requester.
module shared_unit_arb #(
   parameter int N       = 2,
   parameter int LATENCY = 3,
   parameter int II      = 1
) (
   input logic              clock,
   input logic              reset,
   shared_unit_arb_if.slave bus
);
   localparam int SW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (II > 1) ? $clog2(II) : 1;

   logic [SW-1:0] r_ptr;
   logic [CW-1:0] r_cd;
   logic          w_elig;
   logic [SW-1:0] w_idx;
   logic [SW-1:0] w_nptr;
   logic [N-1:0]  w_gnt;

   // Scan from the pointer downward so the lowest offset wins last.
   function automatic logic [SW-1:0] f_pick(
      input logic [N-1:0]  rq,
      input logic [SW-1:0] p
   );
      logic [SW-1:0] j;
      f_pick = '0;
      for (int k = N - 1; k >= 0; k--) begin
         j = SW'((int'(p) + k) % N);
         if (rq[j]) f_pick = j;
      end
   endfunction

   always_comb begin
      w_elig = reset & ~bus.hold & (r_cd == '0) & (|bus.req);
      w_idx  = f_pick(bus.req, r_ptr);
      w_nptr = (w_idx == SW'(N - 1)) ? '0 : w_idx + 1'b1;
      w_gnt  = w_elig ? (N'(1) << w_idx) : '0;
   end

   assign bus.gnt = w_gnt;
   assign bus.sel = w_elig ? w_idx : '0;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_ptr <= '0;
         r_cd  <= '0;
      end else if (w_elig) begin
         r_ptr <= w_nptr;
         r_cd  <= CW'(II - 1);
      end else if (r_cd != '0) begin
         r_cd  <= r_cd - 1'b1;
      end
   end

   generate
      if (LATENCY > 0) begin : g_pipe
         logic [LATENCY-1:0] r_vld;
         logic [SW-1:0]      r_tag [LATENCY];

         // The unit never stalls, so tags shift every cycle.
         always_ff @(posedge clock) begin
            if (!reset) begin
               r_vld <= '0;
               for (int s = 0; s < LATENCY; s++) r_tag[s] <= '0;
            end else begin
               r_vld[0] <= w_elig;
               r_tag[0] <= w_elig ? w_idx : '0;
               for (int s = 1; s < LATENCY; s++) begin
                  r_vld[s] <= r_vld[s-1];
                  r_tag[s] <= r_tag[s-1];
               end
            end
         end

         assign bus.done = (reset && r_vld[LATENCY-1])
                         ? (N'(1) << r_tag[LATENCY-1]) : '0;
         assign bus.busy = (|r_vld) | (r_cd != '0);
      end else begin : g_bypass
         assign bus.done = w_gnt;
         assign bus.busy = (r_cd != '0);
      end
   endgenerate
endmodule
